// File: rtl/nonrestoring_divider_pkg.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider_pkg
// Types and constants shared by the M-extension functional units.
//   XLEN        : operand / result width
//   CNT_W       : width of the divider step counter (counts 0..XLEN)
//   fu_state_e  : FREE / BUSY status reported to the issue logic
//   div_state_e : divider control states
//   op_mag()    : two's-complement magnitude of an operand
// -----------------------------------------------------------------------------
package nonrestoring_divider_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN) + 1;

  typedef enum logic {
    FREE = 1'b0,
    BUSY = 1'b1
  } fu_state_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIVIDE   = 2'd1,
    FINALIZE = 2'd2
  } div_state_e;

  // Magnitude of an operand: negated only when it is a negative signed value.
  // The most negative value maps onto itself, which is correct as an unsigned
  // magnitude of 2^(XLEN-1).
  function automatic logic [XLEN-1:0] op_mag(input logic [XLEN-1:0] v,
                                             input logic            neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/nonrestoring_divider.sv
// -----------------------------------------------------------------------------
// nonrestoring_divider
// Sequential radix-2 non-restoring divider for DIV/DIVU/REM/REMU. One quotient
// bit is produced per enabled cycle; divide-by-zero and signed overflow are
// resolved at accept time and skip the iteration entirely. One operation in
// flight at a time.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_n_i      : asynchronous active-low reset
//   clk_en_i     : clock enable, all state holds while low
//   valid_i      : start request, taken only when FREE and enabled
//   signed_i     : 1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   dividend_i   : dividend, sampled on the accept edge
//   divisor_i    : divisor, sampled on the accept edge
//   quotient_o   : registered quotient, held until the next result
//   remainder_o  : registered remainder, held until the next result
//   valid_o      : one enabled-cycle pulse when results update
//   fu_state_o   : FREE while idle, BUSY while an operation is in flight
// -----------------------------------------------------------------------------
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            clk_en_i,
  input  logic            valid_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o,
  output logic            valid_o,
  output fu_state_e       fu_state_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]    r_rem;       // signed partial remainder, one guard bit
  logic [XLEN-1:0]  r_quo;       // dividend magnitude shifting out, quotient in
  logic [XLEN-1:0]  r_dvs;       // divisor magnitude
  logic             r_neg_q;     // negate quotient at finalize
  logic             r_neg_r;     // negate remainder at finalize
  logic             r_fast;      // r_quo/r_rem already hold the final answer
  logic [XLEN-1:0]  r_quotient;
  logic [XLEN-1:0]  r_remainder;
  logic             r_valid;

  div_state_e       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [XLEN:0]    w_rem_nxt;
  logic [XLEN-1:0]  w_quo_nxt;
  logic [XLEN-1:0]  w_dvs_nxt;
  logic             w_neg_q_nxt;
  logic             w_neg_r_nxt;
  logic             w_fast_nxt;
  logic [XLEN-1:0]  w_quotient_nxt;
  logic [XLEN-1:0]  w_remainder_nxt;
  logic             w_valid_nxt;

  // ---------------------------------------------------------------------------
  // Accept-time decode
  // ---------------------------------------------------------------------------
  logic            w_dvd_neg;
  logic            w_dvs_neg;
  logic            w_div_zero;
  logic            w_sovf;

  assign w_dvd_neg  = signed_i & dividend_i[XLEN-1];
  assign w_dvs_neg  = signed_i & divisor_i[XLEN-1];
  assign w_div_zero = (divisor_i == '0);
  assign w_sovf     = signed_i
                    & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                    & (divisor_i  == {XLEN{1'b1}});

  // ---------------------------------------------------------------------------
  // Iteration datapath
  // ---------------------------------------------------------------------------
  // {R,Q} shifted left by one; the top bit of R falls off, which is safe
  // because |R| < |D| <= 2^XLEN keeps every result inside XLEN+1 bits modulo
  // arithmetic, while the sign decision uses the stored (unshifted) R.
  logic [XLEN:0]   w_shift_rem;
  logic [XLEN:0]   w_step_rem;
  logic [XLEN-1:0] w_step_quo;

  assign w_shift_rem = {r_rem[XLEN-1:0], r_quo[XLEN-1]};
  assign w_step_rem  = r_rem[XLEN] ? (w_shift_rem + {1'b0, r_dvs})
                                   : (w_shift_rem - {1'b0, r_dvs});
  assign w_step_quo  = {r_quo[XLEN-2:0], ~w_step_rem[XLEN]};

  // ---------------------------------------------------------------------------
  // Finalize datapath
  // ---------------------------------------------------------------------------
  // A negative final remainder gets one restoring add; only the low XLEN bits
  // are needed since the corrected value lies in [0, |D|).
  logic [XLEN-1:0] w_fix_rem;
  logic [XLEN-1:0] w_fin_quo;
  logic [XLEN-1:0] w_fin_rem;

  assign w_fix_rem = r_rem[XLEN-1:0] + (r_rem[XLEN] ? r_dvs : '0);
  assign w_fin_quo = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_fin_rem = r_neg_r ? (~w_fix_rem + 1'b1) : w_fix_rem;

  // ---------------------------------------------------------------------------
  // Next-state / next-data logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_rem_nxt       = r_rem;
    w_quo_nxt       = r_quo;
    w_dvs_nxt       = r_dvs;
    w_neg_q_nxt     = r_neg_q;
    w_neg_r_nxt     = r_neg_r;
    w_fast_nxt      = r_fast;
    w_quotient_nxt  = r_quotient;
    w_remainder_nxt = r_remainder;
    w_valid_nxt     = 1'b0;           // valid_o is a single enabled-cycle pulse

    case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_cnt_nxt   = '0;
          w_neg_q_nxt = 1'b0;
          w_neg_r_nxt = 1'b0;
          if (w_div_zero) begin
            // RISC-V: quotient all ones, remainder is the raw dividend
            w_quo_nxt   = {XLEN{1'b1}};
            w_rem_nxt   = {1'b0, dividend_i};
            w_dvs_nxt   = '0;
            w_fast_nxt  = 1'b1;
            w_state_nxt = FINALIZE;
          end else if (w_sovf) begin
            // RISC-V: most-negative / -1 returns the dividend, remainder 0
            w_quo_nxt   = dividend_i;
            w_rem_nxt   = '0;
            w_dvs_nxt   = divisor_i;
            w_fast_nxt  = 1'b1;
            w_state_nxt = FINALIZE;
          end else begin
            w_quo_nxt   = op_mag(dividend_i, w_dvd_neg);
            w_rem_nxt   = '0;
            w_dvs_nxt   = op_mag(divisor_i, w_dvs_neg);
            w_neg_q_nxt = w_dvd_neg ^ w_dvs_neg;
            w_neg_r_nxt = w_dvd_neg;
            w_fast_nxt  = 1'b0;
            w_state_nxt = DIVIDE;
          end
        end
      end

      DIVIDE: begin
        w_rem_nxt = w_step_rem;
        w_quo_nxt = w_step_quo;
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_W'(XLEN-1)) begin
          w_state_nxt = FINALIZE;
        end
      end

      FINALIZE: begin
        w_quotient_nxt  = r_fast ? r_quo : w_fin_quo;
        w_remainder_nxt = r_fast ? r_rem[XLEN-1:0] : w_fin_rem;
        w_valid_nxt     = 1'b1;
        w_state_nxt     = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else if (clk_en_i) begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_fast      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_valid     <= 1'b0;
    end else if (clk_en_i) begin
      r_cnt       <= w_cnt_nxt;
      r_rem       <= w_rem_nxt;
      r_quo       <= w_quo_nxt;
      r_dvs       <= w_dvs_nxt;
      r_neg_q     <= w_neg_q_nxt;
      r_neg_r     <= w_neg_r_nxt;
      r_fast      <= w_fast_nxt;
      r_quotient  <= w_quotient_nxt;
      r_remainder <= w_remainder_nxt;
      r_valid     <= w_valid_nxt;
    end
  end

  assign quotient_o  = r_quotient;
  assign remainder_o = r_remainder;
  assign valid_o     = r_valid;
  assign fu_state_o  = (r_state == IDLE) ? FREE : BUSY;

endmodule

// File: doc/nonrestoring_divider.md
# nonrestoring_divider

Sequential radix-2 non-restoring integer divider, the division counterpart of the Booth radix-4 multiplier in the M-extension functional unit. Computes quotient and remainder for signed and unsigned XLEN-bit operands (DIV/DIVU/REM/REMU), one quotient bit per enabled cycle. RISC-V divide-by-zero and signed-overflow results are produced in a single-cycle fast path. Not pipelined: one operation in flight.

## Interface
- XLEN, 32 (from shared package), operand/result width

- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- clk_en_i  in  1  clock enable; when low all state holds
- valid_i  in  1  start request; accepted only when fu_state_o == FREE and clk_en_i == 1
- signed_i  in  1  1 = signed (DIV/REM), 0 = unsigned
- dividend_i  in  XLEN  dividend, sampled on accept edge only
- divisor_i  in  XLEN  divisor, sampled on accept edge only
- quotient_o  out  XLEN  registered quotient
- remainder_o  out  XLEN  registered remainder
- valid_o  out  1  high for exactly one enabled cycle when results are updated
- fu_state_o  out  fu_state_e  FREE in IDLE, BUSY otherwise

## Operation
- States: IDLE, DIVIDE, FINALIZE.
- IDLE, accept: latch sign flags, operand magnitudes (two's-complement negate when signed_i and MSB set), signed_i.
  - divisor == 0 -> FINALIZE with quotient = all ones, remainder = dividend_i (raw).
  - signed_i, dividend == 0x8000_0000, divisor == all ones -> FINALIZE with quotient = 0x8000_0000, remainder = 0.
  - otherwise -> DIVIDE, counter = 0, partial remainder R (XLEN+1 bits, signed) = 0, Q = |dividend|.
- DIVIDE, each enabled cycle: shift {R,Q} left 1; if old R >= 0 then R = R - |D| else R = R + |D|; new Q LSB = ~R[XLEN]. Counter increments; after XLEN steps -> FINALIZE.
- FINALIZE: if R < 0 then R = R + |D|. Quotient negated when signed_i and operand signs differ; remainder negated when signed_i and dividend negative. Register quotient_o, remainder_o; assert valid_o; -> IDLE. Fast-path results bypass correction/negation.
- Inputs other than clk_en_i/rst_n_i are ignored while BUSY.
- quotient_o/remainder_o hold their last values until the next FINALIZE.

## Timing
- Reset (async, any state incl. mid-operation): state IDLE, counter 0, R/Q 0, quotient_o 0, remainder_o 0, valid_o 0, fu_state_o FREE.
- Accept at enabled edge T0; normal path: DIVIDE edges T1..T32, FINALIZE edge T33; valid_o and results visible after T33 (XLEN+1 enabled edges).
- Fast path: FINALIZE at T1; valid_o visible after T1.
- fu_state_o BUSY from after T0 until after the FINALIZE edge; FREE in the same cycle valid_o is high, so a new valid_i may be accepted in the valid_o cycle (back-to-back, zero bubble).
- valid_o deasserts on the next enabled edge; while clk_en_i low it stays high and counting is frozen, extending latency by the number of disabled cycles.

## Structure
- Shared package: XLEN, fu_state_e (FREE/BUSY) already present; add div_state_e {IDLE, DIVIDE, FINALIZE}.
- Counter width $clog2(XLEN)+1.
- No sub-module: the add/subtract step is a single combinational block; a separate module adds no reuse.

## Test plan
- Unsigned 20 / 3 -> after 33 cycles quotient 6, remainder 2, valid_o one-cycle pulse.
- Signed -7 / 2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF; unsigned 0xFFFF_FFFF / 0x10 -> quotient 0x0FFF_FFFF, remainder 0xF.
- 5 / 0 (both modes) -> 1 cycle later quotient 0xFFFF_FFFF, remainder 5; signed 0x8000_0000 / 0xFFFF_FFFF -> quotient 0x8000_0000, remainder 0 after 1 cycle.
- Assert rst_n_i low asynchronously at DIVIDE step 10 -> outputs 0, fu_state_o FREE immediately; next op 100 / 7 gives 14 r 2.
- clk_en_i low 5 cycles mid-DIVIDE -> valid_o after 38 cycles, correct result; operands changed while BUSY -> no effect.
- Back-to-back: valid_i held high, second op accepted on valid_o cycle -> second valid_o exactly 34 cycles after first.
